// File: rtl/sample_framer.sv
// sample_framer: int16 -> IEEE-754 single converter feeding a two-bank
// ping-pong frame buffer that streams whole N-sample frames with sof/eof.
module sample_framer #(
    parameter int N    = 8,
    parameter int LOGN = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_sample,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_sof,
    output logic        out_eof,
    input  logic        out_ready,
    output logic [15:0] frames_out
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state_q, state_d;
    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic [LOGN-1:0]   wr_idx_q, wr_idx_d;
    logic              rd_bank_q, rd_bank_d;
    logic [LOGN-1:0]   rd_idx_q, rd_idx_d;
    logic [15:0]       frames_q, frames_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              out_sof_q, out_sof_d;
    logic              out_eof_q, out_eof_d;

    logic [31:0]       mem_q [2][N];

    logic [16:0]       mag;
    logic [4:0]        lead;
    logic [39:0]       shifted;
    logic [31:0]       conv;
    logic              wr_en;
    logic [LOGN-1:0]   rd_nxt;

    // Exact conversion: magnitude needs 17 bits so -32768 maps to 2^15.
    always_comb begin
        mag = in_sample[15] ? (17'd0 - {in_sample[15], in_sample})
                            : {1'b0, in_sample};
        lead = 5'd0;
        for (int i = 0; i < 17; i++) begin
            if (mag[i]) lead = 5'(i);
        end
        shifted = {mag, 23'd0} >> lead;
        if (mag == 17'd0) conv = 32'd0;
        else conv = {in_sample[15], 8'd127 + {3'd0, lead}, shifted[22:0]};
    end

    assign in_ready   = !full_q[wr_bank_q];
    assign wr_en      = in_valid && in_ready;
    assign rd_nxt     = rd_idx_q + LOGN'(1);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sof    = out_sof_q;
    assign out_eof    = out_eof_q;
    assign frames_out = frames_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_bank_q][wr_idx_q] <= conv;
    end

    always_comb begin
        state_d     = state_q;
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        wr_idx_d    = wr_idx_q;
        rd_bank_d   = rd_bank_q;
        rd_idx_d    = rd_idx_q;
        frames_d    = frames_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;

        if (wr_en) begin
            wr_idx_d = wr_idx_q + LOGN'(1);
            if (wr_idx_q == LOGN'(N-1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d     = STREAM;
                    rd_idx_d    = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = mem_q[rd_bank_q][0];
                    out_sof_d   = 1'b1;
                    out_eof_d   = (N == 1);
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (rd_idx_q != LOGN'(N-1)) begin
                        rd_idx_d   = rd_nxt;
                        out_data_d = mem_q[rd_bank_q][rd_nxt];
                        out_sof_d  = 1'b0;
                        out_eof_d  = (rd_nxt == LOGN'(N-1));
                    end else begin
                        full_d[rd_bank_q] = 1'b0;
                        rd_bank_d         = ~rd_bank_q;
                        rd_idx_d          = '0;
                        frames_d          = frames_q + 16'd1;
                        // Back-to-back frame when the other bank is ready.
                        if (full_q[~rd_bank_q]) begin
                            out_data_d = mem_q[~rd_bank_q][0];
                            out_sof_d  = 1'b1;
                            out_eof_d  = (N == 1);
                        end else begin
                            state_d     = IDLE;
                            out_valid_d = 1'b0;
                            out_sof_d   = 1'b0;
                            out_eof_d   = 1'b0;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            frames_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_bank_q   <= rd_bank_d;
            rd_idx_q    <= rd_idx_d;
            frames_q    <= frames_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
        end
    end

endmodule
